// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer
//   Paces conversions of the serial ADC front end, box-car averages
//   2^AVG_LOG2 raw results into one 8-bit sample, and queues the averaged
//   samples in a small FIFO drained by the MCU-side register logic.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   enable          run conversions while high
//   adc_start       one-cycle start pulse to the ADC front end
//   adc_data        conversion result, sampled when adc_valid=1
//   adc_valid       one-cycle result-valid pulse
//   rd_en           pop request
//   rd_data         registered FIFO head (last popped word)
//   fifo_empty      FIFO holds no entries
//   fifo_full       FIFO holds 2^FIFO_AW entries
//   fifo_count      current occupancy
//   overflow        sticky: averaged sample dropped on a full FIFO
//   timeout_err     sticky: conversion result missed TIMEOUT
//   clr_flags       clears both sticky flags (a same-cycle set wins)
//   busy            conversion FSM not idle
module adc_sample_buffer #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               adc_start,
  input  logic [7:0]         adc_data,
  input  logic               adc_valid,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               timeout_err,
  input  logic               clr_flags,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned NAVG  = 1 << AVG_LOG2;
  localparam int unsigned PW    = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;

  localparam logic [PW-1:0]    PERIOD_LOAD = PW'(SAMPLE_PERIOD - 2);
  localparam logic [TW-1:0]    TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AVG_DONE    = CNT_W'(NAVG);
  localparam logic [FIFO_AW:0] FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, PACE} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      period_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   acc_n;
  logic               got_sample, tmo_hit;
  logic               push_req, pop, do_push;
  logic [7:0]         push_word;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         mem [DEPTH];

  // enable low overrides everything in the active states
  assign got_sample = (state == WAIT) && enable && adc_valid;
  assign tmo_hit    = (state == WAIT) && enable && !adc_valid && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = TRIG;
      TRIG:    state_nxt = WAIT;
      WAIT:    if (got_sample || tmo_hit) state_nxt = PACE;
      PACE:    if (period_cnt == '0) state_nxt = TRIG;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !enable) state_nxt = IDLE;
  end

  // Outputs
  always_comb begin
    adc_start = (state == TRIG);
    busy      = (state != IDLE);
  end

  // The TRIG cycle itself is the first tick of the period, so the counter
  // is loaded one below SAMPLE_PERIOD-1; it saturates at zero so a long
  // WAIT leaves PACE after a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (state == TRIG)          period_cnt <= PERIOD_LOAD;
      else if (period_cnt != '0)  period_cnt <= period_cnt - PW'(1);
      if (state == TRIG)          tmo_cnt <= '0;
      else if (state == WAIT)     tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Accumulator: a completed average is pushed the cycle after its final
  // add, even if enable drops in that cycle.
  assign push_req  = (acc_n == AVG_DONE);
  assign push_word = acc[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      acc_n <= '0;
    end else if (push_req || !enable) begin
      acc   <= '0;
      acc_n <= '0;
    end else if (got_sample) begin
      acc   <= acc + ACC_W'(adc_data);
      acc_n <= acc_n + CNT_W'(1);
    end
  end

  // FIFO: a pop frees the slot for a same-cycle push when full; when full
  // wr_ptr==rd_ptr, and the read sees the old word.
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign pop        = rd_en && !fifo_empty;
  assign do_push    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rd_data     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + FIFO_AW'(1);
      end
      if (do_push && !pop)      fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
      else if (pop && !do_push) fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
      overflow    <= (push_req && fifo_full && !pop) || (overflow && !clr_flags);
      timeout_err <= tmo_hit || (timeout_err && !clr_flags);
    end
  end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Bench for adc_sample_buffer: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// timing/queue model of the conversion pacing, averaging and FIFO.
module tb_adc_sample_buffer;

  localparam int SP    = 20;
  localparam int L     = 2;
  localparam int FAW   = 2;
  localparam int TO    = 8;
  localparam int DEPTH = 1 << FAW;
  localparam int NAVG  = 1 << L;

  logic           clk = 1'b0;
  logic           rst, enable, adc_start, adc_valid, rd_en;
  logic           fifo_empty, fifo_full, overflow, timeout_err, clr_flags, busy;
  logic [7:0]     adc_data, rd_data;
  logic [FAW:0]   fifo_count;

  adc_sample_buffer #(
    .SAMPLE_PERIOD(SP),
    .AVG_LOG2(L),
    .FIFO_AW(FAW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_start(adc_start),
    .adc_data(adc_data), .adc_valid(adc_valid), .rd_en(rd_en),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err),
    .clr_flags(clr_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- model state (describes the current cycle) -------------
  int         cyc;
  bit         m_busy, m_start, waiting, pend, m_ovf, m_to, chk;
  int         last_start, next_start, sum, m_n;
  logic [7:0] pend_val, m_rd;
  logic [7:0] q[$];

  // ---------------- stimulus control ---------------------------------------
  int resp_delay;   // -1: never answer, -2: random per start
  int resp_at;
  int stray_pct;
  int dq[$];        // data values handed out on answered conversions
  int starts[$];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed value.
  task automatic lit(string nm, logic [31:0] dut_v, logic [31:0] mdl_v, logic [31:0] exp);
    cmp({nm, "_dut"}, dut_v, exp);
    cmp({nm, "_mdl"}, mdl_v, exp);
  endtask

  task automatic model_reset();
    cyc = 0; m_busy = 0; m_start = 0; waiting = 0; pend = 0;
    m_ovf = 0; m_to = 0; sum = 0; m_n = 0; next_start = -1; last_start = 0;
    q.delete(); m_rd = 8'h00; pend_val = 8'h00;
  endtask

  // Advance the model across one clock edge using the inputs of cycle cyc.
  task automatic model_step();
    bit         push_now, set_ovf, set_to;
    logic [7:0] pv;
    push_now = pend; pv = pend_val; pend = 0;
    set_ovf = 0; set_to = 0;
    if (rd_en && q.size() != 0) m_rd = q.pop_front();
    if (push_now) begin
      if (q.size() < DEPTH) q.push_back(pv);
      else set_ovf = 1;
    end
    if (!m_busy) begin
      if (enable) begin m_busy = 1; next_start = cyc + 1; end
    end else if (!enable) begin
      m_busy = 0; waiting = 0; sum = 0; m_n = 0; next_start = -1;
    end else if (cyc == next_start) begin
      last_start = cyc; waiting = 1; next_start = -1;
    end else if (waiting && (adc_valid || cyc - last_start == TO)) begin
      if (adc_valid) begin
        sum += int'(adc_data); m_n++;
        if (m_n == NAVG) begin pend = 1; pend_val = 8'(sum >> L); sum = 0; m_n = 0; end
      end else begin
        set_to = 1;
      end
      waiting = 0;
      // next start: one period after the last, but never before two cycles on
      next_start = (last_start + SP > cyc + 2) ? last_start + SP : cyc + 2;
    end
    m_ovf = set_ovf || (m_ovf && !clr_flags);
    m_to  = set_to  || (m_to  && !clr_flags);
    cyc++;
    m_start = m_busy && (cyc == next_start);
  endtask

  task automatic tick();
    int d;
    @(posedge clk);
    model_step();
    #1;
    if (!m_busy) resp_at = -1;
    if (m_start) begin
      d = resp_delay;
      if (d == -2) d = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(TO + 3, 1));
      resp_at = (d < 0) ? -1 : cyc + d;
    end
    if (cyc == resp_at) begin
      adc_valid = 1'b1;
      adc_data  = (dq.size() != 0) ? 8'(dq.pop_front()) : 8'($urandom);
    end else begin
      adc_valid = (stray_pct != 0) && (int'($urandom_range(99)) < stray_pct);
      adc_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    chk = 0; rst = 1; enable = 0; adc_valid = 0; adc_data = 0;
    rd_en = 0; clr_flags = 0; resp_at = -1;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst = 0;
    chk = 1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk) begin
      cmp("adc_start",   adc_start,   m_start);
      cmp("busy",        busy,        m_busy);
      cmp("rd_data",     rd_data,     m_rd);
      cmp("fifo_count",  fifo_count,  q.size());
      cmp("fifo_empty",  fifo_empty,  q.size() == 0);
      cmp("fifo_full",   fifo_full,   q.size() == DEPTH);
      cmp("overflow",    overflow,    m_ovf);
      cmp("timeout_err", timeout_err, m_to);
      if (adc_start) starts.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ev;
    bit did, done;
    stray_pct = 0; resp_delay = 3;

    // ---- reset values ----
    do_reset();
    lit("rst_busy",  busy,        m_busy,     0);
    lit("rst_start", adc_start,   m_start,    0);
    lit("rst_count", fifo_count,  q.size(),   0);
    lit("rst_empty", fifo_empty,  q.size()==0, 1);
    lit("rst_full",  fifo_full,   q.size()==DEPTH, 0);
    lit("rst_ovf",   overflow,    m_ovf,      0);
    lit("rst_to",    timeout_err, m_to,       0);
    lit("rst_rd",    rd_data,     m_rd,       0);

    // ---- 1: four results 10..13 average to 11 ----
    dq = '{10, 11, 12, 13}; resp_delay = 3; starts.delete();
    enable = 1;
    repeat (70) tick();
    enable = 0;
    tick(); tick();
    cmp("t1_nstarts", starts.size() >= 3, 1);
    if (starts.size() >= 3) begin
      cmp("t1_gap1", starts[1] - starts[0], SP);
      cmp("t1_gap2", starts[2] - starts[1], SP);
    end
    lit("t1_count", fifo_count, q.size(), 1);
    rd_en = 1; tick(); rd_en = 0;
    lit("t1_rd", rd_data, m_rd, 11);

    // ---- 2: no answer -> timeout nine cycles after start, next start on time ----
    dq.delete(); resp_delay = -1;
    enable = 1; tick();
    lit("t2_start", adc_start, m_start, 1);
    repeat (8) tick();
    lit("t2_to_pre", timeout_err, m_to, 0);
    tick();
    lit("t2_to", timeout_err, m_to, 1);
    repeat (11) tick();
    lit("t2_next_start", adc_start, m_start, 1);
    lit("t2_count", fifo_count, q.size(), 0);
    enable = 0; clr_flags = 1; tick(); clr_flags = 0; tick();

    // ---- 3: twenty 0xFF averages without reading ----
    dq.delete(); for (int i = 0; i < 80; i++) dq.push_back(255); resp_delay = 3;
    enable = 1;
    repeat (1600) tick();
    enable = 0; tick();
    lit("t3_full",  fifo_full,  q.size() == DEPTH, 1);
    lit("t3_count", fifo_count, q.size(), 4);
    lit("t3_ovf",   overflow,   m_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; tick(); rd_en = 0;
      lit("t3_drain", rd_data, m_rd, 255);
    end
    lit("t3_empty", fifo_empty, q.size() == 0, 1);
    rd_en = 1; tick(); rd_en = 0;
    lit("t3_rd_hold", rd_data, m_rd, 255);
    lit("t3_empty2",  fifo_empty, q.size() == 0, 1);
    clr_flags = 1; tick(); clr_flags = 0;

    // ---- 4: pop in the push cycle while full, order across wrap ----
    dq.delete();
    for (int v = 1; v <= 5; v++) for (int k = 0; k < 4; k++) dq.push_back(v);
    enable = 1; did = 0; done = 0;
    for (int i = 0; i < 2500 && !done; i++) begin
      tick(); rd_en = 0;
      if (did) done = 1;
      else if (pend && q.size() == DEPTH) begin rd_en = 1; did = 1; end
    end
    cmp("t4_push_seen", did, 1);
    lit("t4_count", fifo_count, q.size(), 4);
    lit("t4_ovf",   overflow,   m_ovf, 0);
    lit("t4_rd1",   rd_data,    m_rd, 1);
    enable = 0; tick();
    for (int v = 2; v <= 5; v++) begin
      rd_en = 1; tick(); rd_en = 0;
      lit("t4_order", rd_data, m_rd, v);
    end

    // ---- 5: partial accumulation discarded on enable drop ----
    dq = '{99, 77, 40, 40, 40, 40};
    enable = 1;
    for (int i = 0; i < 300 && m_n != 2; i++) tick();
    cmp("t5_partial", m_n, 2);
    enable = 0; repeat (3) tick();
    enable = 1;
    for (int i = 0; i < 400 && q.size() != 1; i++) tick();
    enable = 0; tick();
    lit("t5_count", fifo_count, q.size(), 1);
    rd_en = 1; tick(); rd_en = 0;
    lit("t5_avg", rd_data, m_rd, 40);

    // ---- 6: overflow set wins over a same-cycle clear ----
    dq.delete(); ev = 0;
    enable = 1;
    for (int i = 0; i < 1500 && ev < 2; i++) begin
      tick(); clr_flags = 0;
      if (pend && q.size() == DEPTH) begin
        ev++;
        if (ev == 2) begin
          lit("t6_ovf_pre", overflow, m_ovf, 1);
          clr_flags = 1;
        end
      end
    end
    cmp("t6_events", ev, 2);
    tick(); clr_flags = 0;
    lit("t6_ovf_hold", overflow, m_ovf, 1);
    enable = 0; clr_flags = 1; tick(); clr_flags = 0;
    lit("t6_ovf_clr", overflow,    m_ovf, 0);
    lit("t6_to_clr",  timeout_err, m_to,  0);

    // ---- randomized traffic ----
    do_reset();
    dq.delete(); resp_delay = -2; stray_pct = 3;
    enable = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      rd_en     = int'($urandom_range(99)) < (((i / 500) % 2 == 1) ? 5 : 40);
      clr_flags = int'($urandom_range(99)) < 3;
      if ($urandom_range(99) < 2) enable = !enable;
    end
    rd_en = 0; clr_flags = 0; enable = 0;
    tick(); tick();
    chk = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
Downstream consumer of the serial ADC front end. Paces conversions by issuing periodic start pulses, collects each 8-bit result on its valid pulse, and box-car averages 2^AVG_LOG2 results into one 8-bit sample. Averaged samples are queued in a small FIFO that the microcontroller-side register logic drains. Sticky error flags are provided for FIFO overflow and missing conversions.

Parameters:
SAMPLE_PERIOD, 1000, clk cycles between successive adc_start pulses (min 4).
AVG_LOG2, 2, log2 of the number of raw results per averaged sample (0 means no averaging).
FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW.
TIMEOUT, 255, max clk cycles to wait for adc_valid after adc_start.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run conversions while high
adc_start  out  1  one-cycle start pulse to the ADC front end
adc_data  in  8  conversion result, sampled when adc_valid=1
adc_valid  in  1  one-cycle pulse, result valid
rd_en  in  1  pop request from MCU side
rd_data  out  8  FIFO head, registered
fifo_empty  out  1  FIFO holds 0 entries
fifo_full  out  1  FIFO holds 2^FIFO_AW entries
fifo_count  out  FIFO_AW+1  current occupancy
overflow  out  1  sticky: averaged sample dropped because FIFO was full
timeout_err  out  1  sticky: conversion missed TIMEOUT
clr_flags  in  1  clears both sticky flags
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; adc_start=0, rd_data=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, timeout_err=0, busy=0. Accumulator, sample count, period counter and timeout counter are all cleared.
- FSM states: IDLE, TRIG, WAIT, PACE.
  - IDLE: when enable=1, go to TRIG.
  - TRIG: assert adc_start for exactly one cycle, load the period counter with SAMPLE_PERIOD-1, clear the timeout counter, go to WAIT.
  - WAIT: on adc_valid, add adc_data to the accumulator, increment the sample count, go to PACE. If the timeout counter reaches TIMEOUT first, set timeout_err, leave the accumulator unchanged, go to PACE.
  - PACE: when the period counter reaches 0, go to TRIG if enable=1, else IDLE.
- The period counter decrements every cycle from TRIG onward. Start pulses are therefore exactly SAMPLE_PERIOD cycles apart unless WAIT outlasts the period; in that case TRIG follows PACE entry by one cycle.
- enable=0 in TRIG, WAIT or PACE: go to IDLE on the next cycle, discard the partial accumulation (accumulator and count cleared). FIFO contents are retained.
- adc_valid outside WAIT is ignored.
- Accumulator width is 8+AVG_LOG2 bits. When the count reaches 2^AVG_LOG2:
  - push accumulator>>AVG_LOG2 (truncating) into the FIFO on the same cycle as the final add's registration (one cycle after that adc_valid);
  - clear accumulator and count.
- FIFO:
  - rd_en with fifo_empty=0 pops; rd_data updates to the popped word on the next cycle and holds otherwise.
  - rd_en while empty is ignored; rd_data holds.
  - Push with full and no pop: word dropped, overflow set, count unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop is ignored, the push happens.
  - Pointers wrap modulo 2^FIFO_AW.
- Sticky flags: clr_flags clears them; a set event in the same cycle as clr_flags wins (flag reads 1).
- busy = (state != IDLE).

Test Plan:
(Parameters for all: SAMPLE_PERIOD=20, AVG_LOG2=2, FIFO_AW=2, TIMEOUT=8.)
1. Reset, then enable=1: adc_start pulses at cycles t, t+20, t+40. Respond with valid 3 cycles after each start, values 10,11,12,13 -> one push, fifo_count=1; after rd_en, rd_data=11 on the next cycle.
2. Never assert adc_valid -> timeout_err=1 nine cycles after the start. The next start still occurs 20 cycles after the previous one, and no FIFO push happens.
3. Feed 20 averaged samples of 0xFF without reading -> fifo_full=1, fifo_count=4, overflow=1. Drain 4 reads returning 0xFF; a fifth rd_en leaves rd_data=0xFF and fifo_empty=1.
4. With FIFO full, assert rd_en in the push cycle -> count stays 4, overflow stays 0, and read order is preserved across pointer wrap.
5. Deassert enable after 2 of 4 raw samples, then re-enable and give 4 samples of 40 -> the pushed average is 40; the partial samples are discarded.
6. With overflow=1, assert clr_flags in the same cycle as a new overflow event -> overflow remains 1. Assert clr_flags alone -> overflow=0 and timeout_err=0.
